// File: rtl/my_pkg.sv
// Shared parameters, constants and FSM state type for the direct-mapped instruction cache.
package my_pkg;
    localparam int unsigned ICACHE_LINES   = 16;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned TAG_W          = 24;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

    typedef enum logic {
        IC_IDLE,
        IC_FILL
    } icache_state_t;
endpackage

// File: rtl/icache_data_array.sv
// Instruction word storage: one synchronous write port, one combinational read port, no reset.
module icache_data_array #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: zero-cycle lookup, line refill FSM fed by the miss controller.
module icache_dm
    import my_pkg::*;
#(
    parameter int unsigned ICACHE_LINES   = my_pkg::ICACHE_LINES,
    parameter int unsigned WORDS_PER_LINE = my_pkg::WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc_addr,
    input  logic        flush,
    input  logic        refill_we_n,
    input  logic        refill_valid,
    input  logic [31:0] refill_data,
    output logic [31:0] instr,
    output logic        match,
    output logic        busy,
    output logic        refill_done
);
    localparam int unsigned IDX_W  = $clog2(ICACHE_LINES);
    localparam int unsigned WORD_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned OFF_W  = WORD_W + 2;
    localparam int unsigned LTAG_W = 32 - OFF_W - IDX_W;

    icache_state_t state_q, state_d;

    logic [ICACHE_LINES-1:0] valid_q;
    logic [LTAG_W-1:0]       tag_q [ICACHE_LINES];
    logic [IDX_W-1:0]        fill_idx_q;
    logic [LTAG_W-1:0]       fill_tag_q;
    logic [WORD_W-1:0]       cnt_q;
    logic                    done_q;

    logic start, wr_en, last;

    logic [IDX_W-1:0]  lk_idx;
    logic [WORD_W-1:0] lk_word;
    logic [LTAG_W-1:0] lk_tag;
    logic [31:0]       rd_word;
    logic              hit;
    logic              unused_addr_bits;

    assign lk_word          = pc_addr[2 +: WORD_W];
    assign lk_idx           = pc_addr[OFF_W +: IDX_W];
    assign lk_tag           = pc_addr[31 -: LTAG_W];
    assign unused_addr_bits = ^pc_addr[1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // flush has priority over both starting a fill and completing one
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        wr_en   = 1'b0;
        last    = 1'b0;
        case (state_q)
            IC_IDLE: begin
                if (!flush && !refill_we_n) begin
                    start   = 1'b1;
                    state_d = IC_FILL;
                end
            end
            IC_FILL: begin
                if (flush) begin
                    state_d = IC_IDLE;
                end else if (refill_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == WORD_W'(WORDS_PER_LINE - 1)) begin
                        last    = 1'b1;
                        state_d = IC_IDLE;
                    end
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q    <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= last;
            if (flush) begin
                valid_q <= '0;
            end else begin
                if (start) valid_q[lk_idx]     <= 1'b0;
                if (last)  valid_q[fill_idx_q] <= 1'b1;
            end
            if (start) begin
                fill_idx_q <= lk_idx;
                fill_tag_q <= lk_tag;
                cnt_q      <= '0;
            end else if (wr_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (last) begin
            tag_q[fill_idx_q] <= fill_tag_q;
        end
    end

    icache_data_array #(
        .DEPTH (ICACHE_LINES * WORDS_PER_LINE),
        .ADDR_W(IDX_W + WORD_W)
    ) u_data (
        .clk  (clk),
        .we   (wr_en),
        .waddr({fill_idx_q, cnt_q}),
        .wdata(refill_data),
        .raddr({lk_idx, lk_word}),
        .rdata(rd_word)
    );

    assign hit         = (state_q == IC_IDLE) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign match       = hit;
    assign instr       = hit ? rd_word : NOP_INSTR;
    assign busy        = (state_q == IC_FILL);
    assign refill_done = done_q;
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: behavioural cache model, per-cycle compare, directed and random stimulus.
module tb_icache_dm;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc_addr = '0;
    logic        flush = 1'b0;
    logic        refill_we_n = 1'b1;
    logic        refill_valid = 1'b0;
    logic [31:0] refill_data = '0;
    logic [31:0] instr;
    logic        match, busy, refill_done;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    icache_dm #(.ICACHE_LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk(clk), .rstn(rstn), .pc_addr(pc_addr), .flush(flush),
        .refill_we_n(refill_we_n), .refill_valid(refill_valid), .refill_data(refill_data),
        .instr(instr), .match(match), .busy(busy), .refill_done(refill_done)
    );

    always #5 clk = ~clk;

    // Reference model: lines as plain arrays, fill tracked as a pending target plus word count
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    logic [31:0] m_data  [16][4];
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [23:0] m_ftag = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            m_busy = 0;
            m_done = 0;
            m_cnt  = 0;
        end else begin
            m_done = 0;
            if (flush) begin
                foreach (m_valid[i]) m_valid[i] = 0;
                m_busy = 0;
            end else if (!m_busy && !refill_we_n) begin
                m_idx  = int'(pc_addr[7:4]);
                m_ftag = pc_addr[31:8];
                m_valid[m_idx] = 0;
                m_cnt  = 0;
                m_busy = 1;
            end else if (m_busy && refill_valid) begin
                m_data[m_idx][m_cnt] = refill_data;
                m_cnt = m_cnt + 1;
                if (m_cnt == 4) begin
                    m_valid[m_idx] = 1;
                    m_tag[m_idx]   = m_ftag;
                    m_busy = 0;
                    m_done = 1;
                    m_cnt  = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int  idx;
        bit  exp_match;
        idx       = int'(pc_addr[7:4]);
        exp_match = !m_busy && m_valid[idx] && (m_tag[idx] == pc_addr[31:8]);
        chk("model_match", 32'(match), 32'(exp_match));
        chk("model_instr", instr, exp_match ? m_data[idx][pc_addr[3:2]] : 32'h0000_0013);
        chk("model_busy", 32'(busy), 32'(m_busy));
        chk("model_done", 32'(refill_done), 32'(m_done));
        if (refill_done === 1'b1) done_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic [31:0] addr);
        pc_addr = addr;
        refill_we_n = 1'b0;
        tick();
        refill_we_n = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        repeat (gap) begin
            refill_valid = 1'b0;
            #1 chk("busy_in_gap", 32'(busy), 32'd1);
            tick();
        end
        #1 chk("busy_before_word", 32'(busy), 32'd1);
        refill_valid = 1'b1;
        refill_data  = d;
        tick();
        refill_valid = 1'b0;
    endtask

    task automatic fill_line(input logic [31:0] addr, input logic [31:0] base, input int gap);
        start_fill(addr);
        for (int i = 0; i < 4; i++) begin
            if (gap > 0) pc_addr = $urandom;
            send_word(base + 32'(i) * 32'h11, gap);
        end
        #1 chk("done_pulse", 32'(refill_done), 32'd1);
        chk("busy_after_fill", 32'(busy), 32'd0);
        tick();
        #1 chk("done_one_cycle", 32'(refill_done), 32'd0);
    endtask

    initial begin
        int d0;
        foreach (m_valid[i]) m_valid[i] = 0;
        #12 rstn = 1'b1;
        tick();

        pc_addr = 32'h0000_0040;
        #1 chk("rst_match", 32'(match), 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_busy", 32'(busy), 32'd0);

        d0 = done_seen;
        fill_line(32'h0000_0040, 32'h11, 0);
        pc_addr = 32'h0000_0048;
        #1 chk("hit_match", 32'(match), 32'd1);
        chk("hit_instr", instr, 32'h0000_0033);
        chk("done_count", 32'(done_seen - d0), 32'd1);

        d0 = done_seen;
        fill_line(32'h0000_0040, 32'h11, 2);
        pc_addr = 32'h0000_0048;
        #1 chk("gap_instr", instr, 32'h0000_0033);
        pc_addr = 32'h0000_004C;
        #1 chk("gap_instr_w3", instr, 32'h0000_0044);
        chk("gap_done_count", 32'(done_seen - d0), 32'd1);

        pc_addr = 32'h0000_0140;
        #1 chk("alias_miss", 32'(match), 32'd0);
        chk("alias_nop", instr, 32'h0000_0013);
        fill_line(32'h0000_0140, 32'hA0, 0);
        pc_addr = 32'h0000_0040;
        #1 chk("alias_old_miss", 32'(match), 32'd0);
        pc_addr = 32'h0000_0144;
        #1 chk("alias_new_hit", 32'(match), 32'd1);
        chk("alias_new_instr", instr, 32'h0000_00B1);

        fill_line(32'h0000_0040, 32'h11, 0);
        d0 = done_seen;
        start_fill(32'h0000_0080);
        send_word(32'h5, 0);
        send_word(32'h6, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1 chk("flush_busy", 32'(busy), 32'd0);
        pc_addr = 32'h0000_0040;
        #1 chk("flush_miss", 32'(match), 32'd0);
        repeat (4) tick();
        chk("flush_no_done", 32'(done_seen - d0), 32'd0);
        flush = 1'b1;
        refill_we_n = 1'b0;
        tick();
        flush = 1'b0;
        refill_we_n = 1'b1;
        #1 chk("flush_wins", 32'(busy), 32'd0);

        fill_line(32'h0000_0040, 32'h11, 0);
        start_fill(32'h0000_0040);
        for (int i = 0; i < 3; i++) send_word(32'h70 + 32'(i), 0);
        rstn = 1'b0;
        #2 chk("rst_mid_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            pc_addr = {24'h0, 4'(i), 4'h0};
            #1 chk("rst_all_miss", 32'(match), 32'd0);
        end

        for (int c = 0; c < 4000; c++) begin
            pc_addr      = {22'h0, 2'($urandom_range(0, 2)), 4'($urandom), 4'($urandom)};
            refill_we_n  = ($urandom % 6) != 0;
            refill_valid = $urandom % 2;
            refill_data  = $urandom;
            flush        = ($urandom % 80) == 0;
            if (($urandom % 700) == 0) begin
                rstn = 1'b0;
                tick();
                rstn = 1'b1;
            end
            tick();
        end
        refill_we_n  = 1'b1;
        refill_valid = 1'b0;
        flush        = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL expose parameter ICACHE_LINES, default 16, number of direct-mapped lines.
REQ-002 SHALL expose parameter WORDS_PER_LINE, default 4, 32-bit instruction words per line.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pc_addr  input  32  byte fetch address; [1:0] ignored, [3:2] word, [7:4] index, [31:8] tag (24 b).
REQ-006 SHALL have port flush  input  1  invalidate all lines.
REQ-007 SHALL have port refill_we_n  input  1  active-low refill start from the miss controller.
REQ-008 SHALL have port refill_valid  input  1  refill_data word valid this cycle.
REQ-009 SHALL have port refill_data  input  32  refill word from instruction memory, lowest word first.
REQ-010 SHALL have port instr  output  32  instruction word at pc_addr.
REQ-011 SHALL have port match  output  1  hit: line valid and tag equal.
REQ-012 SHALL have port busy  output  1  refill in progress.
REQ-013 SHALL have port refill_done  output  1  one-cycle pulse when line becomes valid.

Function
REQ-014 SHALL compute match and instr combinationally from pc_addr and current array state (zero-cycle lookup).
REQ-015 SHALL drive instr = 32'h0000_0013 (NOP) whenever match = 0.
REQ-016 SHALL implement states IC_IDLE and IC_FILL.
REQ-017 IC_IDLE: refill_we_n = 0 and flush = 0 -> latch pc_addr[31:4] as fill tag/index, clear that line's valid bit, word counter = 0, go IC_FILL next cycle.
REQ-018 IC_FILL: each cycle with refill_valid = 1 SHALL write refill_data to word[counter] of the latched index and increment the 2-bit counter.
REQ-019 IC_FILL: write of word WORDS_PER_LINE-1 SHALL set valid, store tag, pulse refill_done in the following cycle, return to IC_IDLE, counter wraps to 0.
REQ-020 busy SHALL equal 1 exactly while in IC_FILL; match SHALL be forced 0 while busy.
REQ-021 refill_we_n low in IC_FILL SHALL be ignored (no restart, latched address unchanged).
REQ-022 refill_valid in IC_IDLE SHALL be ignored (no array write).
REQ-023 flush SHALL clear all valid bits in one cycle; in IC_FILL it SHALL abort the fill, return to IC_IDLE, no refill_done pulse.
REQ-024 flush and refill_we_n low together in IC_IDLE: flush wins, no fill started.
REQ-025 pc_addr changes during IC_FILL SHALL NOT affect the fill target.

Reset
REQ-026 rstn low SHALL asynchronously force state IC_IDLE, counter 0, all valid bits 0, busy 0, refill_done 0, match 0, instr NOP.
REQ-027 Reset mid-fill SHALL discard the partial line; data array contents need no reset.

Structure
REQ-028 Package my_pkg SHALL hold ICACHE_LINES, WORDS_PER_LINE, TAG_W = 24, NOP_INSTR, and enum icache_state_t {IC_IDLE, IC_FILL}.
REQ-029 Data storage SHALL be sub-module icache_data_array (1 write port, 1 combinational read port, no reset); tags, valid bits and FSM stay in icache_dm.

Verification
REQ-030 Reset, pc_addr = 0x0000_0040 -> match 0, instr 0x0000_0013, busy 0.
REQ-031 refill_we_n pulse at pc 0x0000_0040, then words 0x11,0x22,0x33,0x44 with refill_valid -> refill_done one cycle after 4th word; pc 0x48 -> match 1, instr 0x33.
REQ-032 Refill as above with refill_valid gaps of 2 cycles between words -> busy held 1 throughout, same final contents, single refill_done.
REQ-033 Fill line index 4 with tag 0x000000, then pc 0x0000_0140 (same index, tag 0x000001) -> match 0; refill it -> pc 0x40 misses, 0x140 hits.
REQ-034 flush asserted after 2nd refill word -> busy 0 next cycle, no refill_done, pc 0x40 match 0; flush with refill_we_n low in IDLE -> busy stays 0.
REQ-035 rstn low after 3rd refill word -> busy 0, match 0 for all addresses after release.
